// File: rtl/ila_trigger.sv
// ila_trigger: two-condition mask/match/edge trigger sequencer with an occurrence counter, feeding an ILA.
// Optional STAGE1 timeout window is compiled in when ILA_TRIG_TIMEOUT_EN is defined.
`default_nettype none

package reg_map_pkg;
    localparam logic [31:0] R_ILA_TRIG_CTRL   = 32'h0000_0000;
    localparam logic [31:0] R_ILA_TRIG_MATCH0 = 32'h0000_0004;
    localparam logic [31:0] R_ILA_TRIG_MASK0  = 32'h0000_0008;
    localparam logic [31:0] R_ILA_TRIG_EDGE0  = 32'h0000_000C;
    localparam logic [31:0] R_ILA_TRIG_MATCH1 = 32'h0000_0010;
    localparam logic [31:0] R_ILA_TRIG_MASK1  = 32'h0000_0014;
    localparam logic [31:0] R_ILA_TRIG_EDGE1  = 32'h0000_0018;
    localparam logic [31:0] R_ILA_TRIG_COUNT  = 32'h0000_001C;
    localparam logic [31:0] R_ILA_TRIG_WINDOW = 32'h0000_0020;
endpackage

module ila_trigger #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sample_in,
    output logic [WIDTH-1:0] sample_out,
    output logic             trigger_out,
    input  logic [31:0]      bus_addr,
    input  logic             bus_wen,
    input  logic             bus_ren,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      bus_rdata
);
    import reg_map_pkg::*;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STAGE0 = 2'd1,
        S_STAGE1 = 2'd2,
        S_FIRED  = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_seq_en;
    logic [WIDTH-1:0] r_match0, r_mask0, r_edge0;
    logic [WIDTH-1:0] r_match1, r_mask1, r_edge1;
    logic [15:0]      r_target;
    logic [15:0]      r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_prev_sample;
    logic             r_prev_valid;
    logic             w_fire;
`ifdef ILA_TRIG_TIMEOUT_EN
    logic [15:0]      r_window;
    logic [15:0]      r_tmo, w_tmo_nxt;
`endif

    logic w_ctrl_wr;
    logic w_hit0, w_hit1;
    logic w_edge0_ok, w_edge1_ok;
    logic [16:0] w_cnt_inc;
    logic [15:0] w_tgt_eff;
    logic w_reach;
    logic w_unused_ok;

    assign w_unused_ok = &{1'b0, bus_ren, bus_wdata};
    assign w_ctrl_wr   = bus_wen && (bus_addr == R_ILA_TRIG_CTRL);

    // Edge bits demand a toggle against a valid previous sample; the match term picks the direction.
    assign w_edge0_ok = (r_edge0 == '0) ||
                        (r_prev_valid && (((sample_in ^ r_prev_sample) & r_edge0) == r_edge0));
    assign w_edge1_ok = (r_edge1 == '0) ||
                        (r_prev_valid && (((sample_in ^ r_prev_sample) & r_edge1) == r_edge1));
    assign w_hit0 = (((sample_in ^ r_match0) & r_mask0) == '0) && w_edge0_ok;
    assign w_hit1 = (((sample_in ^ r_match1) & r_mask1) == '0) && w_edge1_ok;

    assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;
    assign w_tgt_eff = (r_target == 16'd0) ? 16'd1 : r_target;
    assign w_reach   = (w_cnt_inc >= {1'b0, w_tgt_eff});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq_en <= 1'b0;
            r_match0 <= '0;
            r_mask0  <= '0;
            r_edge0  <= '0;
            r_match1 <= '0;
            r_mask1  <= '0;
            r_edge1  <= '0;
            r_target <= 16'd0;
`ifdef ILA_TRIG_TIMEOUT_EN
            r_window <= 16'd0;
`endif
        end else if (bus_wen) begin
            case (bus_addr)
                R_ILA_TRIG_CTRL:   r_seq_en <= bus_wdata[1];
                R_ILA_TRIG_MATCH0: r_match0 <= bus_wdata[WIDTH-1:0];
                R_ILA_TRIG_MASK0:  r_mask0  <= bus_wdata[WIDTH-1:0];
                R_ILA_TRIG_EDGE0:  r_edge0  <= bus_wdata[WIDTH-1:0];
                R_ILA_TRIG_MATCH1: r_match1 <= bus_wdata[WIDTH-1:0];
                R_ILA_TRIG_MASK1:  r_mask1  <= bus_wdata[WIDTH-1:0];
                R_ILA_TRIG_EDGE1:  r_edge1  <= bus_wdata[WIDTH-1:0];
                R_ILA_TRIG_COUNT:  r_target <= bus_wdata[15:0];
`ifdef ILA_TRIG_TIMEOUT_EN
                R_ILA_TRIG_WINDOW: r_window <= bus_wdata[15:0];
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= 16'd0;
            r_prev_sample <= '0;
            r_prev_valid  <= 1'b0;
            sample_out    <= '0;
            trigger_out   <= 1'b0;
`ifdef ILA_TRIG_TIMEOUT_EN
            r_tmo         <= 16'd0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_prev_sample <= sample_in;
            r_prev_valid  <= !w_ctrl_wr;
            sample_out    <= sample_in;
            trigger_out   <= w_fire;
`ifdef ILA_TRIG_TIMEOUT_EN
            r_tmo         <= w_tmo_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fire      = 1'b0;
`ifdef ILA_TRIG_TIMEOUT_EN
        w_tmo_nxt   = r_tmo;
`endif
        if (w_ctrl_wr) begin
            if (bus_wdata[0]) begin
                w_state_nxt = S_STAGE0;
                w_cnt_nxt   = 16'd0;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end else begin
            case (r_state)
                S_STAGE0: begin
                    if (w_hit0) begin
                        if (w_reach) begin
                            if (r_seq_en) begin
                                w_state_nxt = S_STAGE1;
`ifdef ILA_TRIG_TIMEOUT_EN
                                w_tmo_nxt   = r_window;
`endif
                            end else begin
                                w_state_nxt = S_FIRED;
                                w_fire      = 1'b1;
                            end
                        end else begin
                            w_cnt_nxt = w_cnt_inc[16] ? 16'hFFFF : w_cnt_inc[15:0];
                        end
                    end
                end
                S_STAGE1: begin
                    if (w_hit1) begin
                        w_state_nxt = S_FIRED;
                        w_fire      = 1'b1;
                    end
`ifdef ILA_TRIG_TIMEOUT_EN
                    // A loaded window of 0 never expires.
                    else if (r_tmo != 16'd0) begin
                        if (r_tmo == 16'd1) begin
                            w_state_nxt = S_STAGE0;
                            w_cnt_nxt   = 16'd0;
                            w_tmo_nxt   = 16'd0;
                        end else begin
                            w_tmo_nxt = r_tmo - 16'd1;
                        end
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus_rdata = 32'd0;
        case (bus_addr)
            R_ILA_TRIG_CTRL:   bus_rdata = {28'd0, r_state, r_seq_en,
                                            (r_state == S_STAGE0) || (r_state == S_STAGE1)};
            R_ILA_TRIG_MATCH0: bus_rdata = 32'(r_match0);
            R_ILA_TRIG_MASK0:  bus_rdata = 32'(r_mask0);
            R_ILA_TRIG_EDGE0:  bus_rdata = 32'(r_edge0);
            R_ILA_TRIG_MATCH1: bus_rdata = 32'(r_match1);
            R_ILA_TRIG_MASK1:  bus_rdata = 32'(r_mask1);
            R_ILA_TRIG_EDGE1:  bus_rdata = 32'(r_edge1);
            R_ILA_TRIG_COUNT:  bus_rdata = {r_cnt, r_target};
`ifdef ILA_TRIG_TIMEOUT_EN
            R_ILA_TRIG_WINDOW: bus_rdata = {16'd0, r_window};
`endif
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_ila_trigger.sv
// tb_ila_trigger: directed scoreboard bench for ila_trigger (trigger pulse, sample alignment, register reads).
`default_nettype none

module tb_ila_trigger;
    import reg_map_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] sample_in = '0;
    logic [31:0] sample_out;
    logic        trigger_out;
    logic [31:0] bus_addr = '0;
    logic        bus_wen = 1'b0;
    logic        bus_ren = 1'b0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;

    int errors = 0;
    int checks = 0;
    logic [32:0] sb_q[$];

    ila_trigger #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_out(sample_out),
        .trigger_out(trigger_out), .bus_addr(bus_addr), .bus_wen(bus_wen),
        .bus_ren(bus_ren), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: optionally a bus write, always a sample; scoreboard holds the expected output.
    task automatic cyc(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] s, input logic exp_trig, input string tag);
        logic [32:0] e;
        @(negedge clk);
        bus_wen   = wen;
        bus_addr  = addr;
        bus_wdata = wd;
        sample_in = s;
        sb_q.push_back({exp_trig, s});
        @(posedge clk);
        #1;
        bus_wen = 1'b0;
        e = sb_q.pop_front();
        chk({tag, ".trig"}, {31'd0, trigger_out}, {31'd0, e[32]});
        chk({tag, ".sout"}, sample_out, e[31:0]);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] s);
        cyc(1'b1, addr, wd, s, 1'b0, "wr");
    endtask

    task automatic step(input logic [31:0] s, input logic exp_trig, input string tag);
        cyc(1'b0, 32'hFFFF_FFF0, 32'd0, s, exp_trig, tag);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        bus_addr = addr;
        #1;
        chk(tag, bus_rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] regs [9];
        regs = '{R_ILA_TRIG_CTRL, R_ILA_TRIG_MATCH0, R_ILA_TRIG_MASK0, R_ILA_TRIG_EDGE0,
                 R_ILA_TRIG_MATCH1, R_ILA_TRIG_MASK1, R_ILA_TRIG_EDGE1, R_ILA_TRIG_COUNT,
                 R_ILA_TRIG_WINDOW};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset.trig", {31'd0, trigger_out}, 32'd0);
        chk("reset.sout", sample_out, 32'd0);
        rd(R_ILA_TRIG_CTRL, 32'h0, "reset.ctrl");

        // Basic match
        wr(R_ILA_TRIG_MASK0, 32'hFF, 32'h0);
        wr(R_ILA_TRIG_MATCH0, 32'h5A, 32'h0);
        rd(R_ILA_TRIG_MATCH0, 32'h5A, "basic.match0_rd");
        wr(R_ILA_TRIG_CTRL, 32'h1, 32'h0);
        rd(R_ILA_TRIG_CTRL, 32'h5, "basic.armed");
        step(32'h00, 1'b0, "basic.s0");
        step(32'h5A, 1'b1, "basic.s1");
        step(32'h5A, 1'b0, "basic.s2");
        rd(R_ILA_TRIG_CTRL, 32'hC, "basic.fired");

        // Occurrence count
        wr(R_ILA_TRIG_COUNT, 32'd3, 32'h0);
        wr(R_ILA_TRIG_CTRL, 32'h1, 32'h0);
        step(32'h5A, 1'b0, "cnt.s0");
        step(32'h00, 1'b0, "cnt.s1");
        step(32'h5A, 1'b0, "cnt.s2");
        rd(R_ILA_TRIG_COUNT, 32'h0002_0003, "cnt.read");
        step(32'h00, 1'b0, "cnt.s3");
        step(32'h5A, 1'b1, "cnt.s4");
        rd(R_ILA_TRIG_CTRL, 32'hC, "cnt.fired");

        // Rising edge toward MATCH0 = 1
        wr(R_ILA_TRIG_COUNT, 32'd0, 32'h1);
        wr(R_ILA_TRIG_MASK0, 32'h1, 32'h1);
        wr(R_ILA_TRIG_MATCH0, 32'h1, 32'h1);
        wr(R_ILA_TRIG_EDGE0, 32'h1, 32'h1);
        wr(R_ILA_TRIG_CTRL, 32'h1, 32'h1);
        step(32'h1, 1'b0, "edge.hold0");
        step(32'h1, 1'b0, "edge.hold1");
        step(32'h0, 1'b0, "edge.fall");
        step(32'h1, 1'b1, "edge.rise");

        // Two-stage sequence
        wr(R_ILA_TRIG_EDGE0, 32'h0, 32'h0);
        wr(R_ILA_TRIG_MASK0, 32'hFF, 32'h0);
        wr(R_ILA_TRIG_MATCH0, 32'h01, 32'h0);
        wr(R_ILA_TRIG_MASK1, 32'hFF, 32'h0);
        wr(R_ILA_TRIG_MATCH1, 32'h02, 32'h0);
        wr(R_ILA_TRIG_CTRL, 32'h3, 32'h0);
        step(32'h02, 1'b0, "seq.s0");
        rd(R_ILA_TRIG_CTRL, 32'h7, "seq.st1");
        step(32'h01, 1'b0, "seq.s1");
        rd(R_ILA_TRIG_CTRL, 32'hB, "seq.st2a");
        step(32'h03, 1'b0, "seq.s2");
        rd(R_ILA_TRIG_CTRL, 32'hB, "seq.st2b");
        step(32'h02, 1'b1, "seq.s3");
        rd(R_ILA_TRIG_CTRL, 32'hE, "seq.fired");

        // CTRL write beats a same-cycle hit
        wr(R_ILA_TRIG_CTRL, 32'h1, 32'h0);
        wr(R_ILA_TRIG_CTRL, 32'h0, 32'h01);
        step(32'h01, 1'b0, "prio.after");
        rd(R_ILA_TRIG_CTRL, 32'h0, "prio.idle");

        // Reset from STAGE1
        wr(R_ILA_TRIG_COUNT, 32'd7, 32'h0);
        wr(R_ILA_TRIG_COUNT, 32'd0, 32'h0);
        wr(R_ILA_TRIG_CTRL, 32'h3, 32'h0);
        step(32'h01, 1'b0, "rst.to_s1");
        rd(R_ILA_TRIG_CTRL, 32'hB, "rst.in_s1");
        @(negedge clk);
        rst = 1'b1;
        sample_in = 32'h02;
        @(posedge clk);
        #1;
        chk("rst.trig", {31'd0, trigger_out}, 32'd0);
        chk("rst.sout", sample_out, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) rd(regs[i], 32'd0, "rst.regs");
        rd(32'h0000_0100, 32'd0, "unmapped");

        // WINDOW register exists only in the timeout build
        wr(R_ILA_TRIG_WINDOW, 32'd4, 32'h0);
`ifdef ILA_TRIG_TIMEOUT_EN
        rd(R_ILA_TRIG_WINDOW, 32'd4, "win.read");
        wr(R_ILA_TRIG_MASK0, 32'hFF, 32'h0);
        wr(R_ILA_TRIG_MATCH0, 32'h01, 32'h0);
        wr(R_ILA_TRIG_MASK1, 32'hFF, 32'h0);
        wr(R_ILA_TRIG_MATCH1, 32'h02, 32'h0);
        wr(R_ILA_TRIG_CTRL, 32'h3, 32'h0);
        step(32'h01, 1'b0, "tmo.hit0");
        step(32'h00, 1'b0, "tmo.w1");
        step(32'h00, 1'b0, "tmo.w2");
        step(32'h00, 1'b0, "tmo.w3");
        rd(R_ILA_TRIG_CTRL, 32'hB, "tmo.still_s1");
        step(32'h00, 1'b0, "tmo.w4");
        rd(R_ILA_TRIG_CTRL, 32'h7, "tmo.back_s0");
        step(32'h02, 1'b0, "tmo.late_hit1");
        rd(R_ILA_TRIG_COUNT, 32'h0, "tmo.cnt");
`else
        rd(R_ILA_TRIG_WINDOW, 32'd0, "win.absent");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ila_trigger.md
Name: ila_trigger

Overview:
Programmable trigger unit placed directly upstream of the ILA capture core. It watches the probed sample bus and evaluates two mask/match/edge conditions through a small sequencer with an occurrence counter. It then drives a single-cycle trigger pulse into the ILA's trigger_in, together with a sample bus delayed to stay cycle-aligned with that pulse. It is configured over the same simple register bus as the ILA, using addresses R_ILA_TRIG_* from reg_map_pkg.

Parameters:
WIDTH, 32, probed sample width in bits; legal range 1..32.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
sample_in  in  WIDTH  raw probed signals
sample_out  out  WIDTH  sample_in delayed 1 cycle; connects to the ILA sample_in
trigger_out  out  1  one-cycle trigger pulse aligned with sample_out; connects to the ILA trigger_in
bus_addr  in  32  register address, compared in full
bus_wen  in  1  write strobe
bus_ren  in  1  read strobe; unused internally because reads are combinational
bus_wdata  in  32  write data
bus_rdata  out  32  read data, combinational from bus_addr; 0 for unmapped addresses

Behaviour:
- Registers (R/W unless noted; fields are WIDTH bits, LSB-aligned, upper bits read 0):
  - R_ILA_TRIG_CTRL: bit0 arm, bit1 seq_en. Read returns bit0 armed, bit1 seq_en, bits 3:2 state.
  - R_ILA_TRIG_MATCH0/MASK0/EDGE0 and R_ILA_TRIG_MATCH1/MASK1/EDGE1.
  - R_ILA_TRIG_COUNT: write bits 15:0 set the cond0 target. Read returns {current cnt, target}.
- Reset values: all config registers 0; state IDLE; cnt 0; trigger_out 0; sample_out 0; prev_valid 0.
- Condition k is true when both hold:
  - ((sample_in ^ MATCHk) & MASKk) == 0.
  - For every bit set in EDGEk: prev_valid = 1 and sample_in bit != previous sample bit. Combined with the match check, this gives a rising or falling edge toward MATCH.
- MASK = 0 and EDGE = 0 means the condition is true every cycle.
- prev_sample is registered every cycle. prev_valid is cleared on reset and on any CTRL write, and set 1 cycle later.
- States: IDLE=0, STAGE0=1, STAGE1=2, FIRED=3.
  - CTRL write with wdata[0]=1: go to STAGE0, cnt=0. This applies from any state, so it is also the re-arm.
  - CTRL write with wdata[0]=0: go to IDLE.
  - A CTRL write takes priority over any condition hit in the same cycle. Nothing advances and no pulse is produced.
  - STAGE0, on a cond0 hit: if cnt+1 >= max(target,1), go to STAGE1 when seq_en=1, otherwise fire. Else increment cnt; cnt saturates at 0xFFFF.
  - STAGE1, on a cond1 hit: fire. Cond0 is ignored in STAGE1.
  - Fire: go to FIRED; trigger_out=1 for exactly 1 cycle.
  - FIRED holds until a CTRL write. No further pulses occur.
- armed = state is STAGE0 or STAGE1.
- Latency: a sample at sample_in in cycle N that causes a fire produces trigger_out=1 in cycle N+1, with sample_out equal to that sample in cycle N+1.
- Config writes other than CTRL take effect the next cycle. They do not alter state or cnt.
- rst asserted in any state returns everything to reset values on the next edge. trigger_out is 0 in the following cycle.

Optional Feature:
Macro ILA_TRIG_TIMEOUT_EN.
- Defined:
  - Adds R/W register R_ILA_TRIG_WINDOW, bits 15:0, reset 0.
  - On entry to STAGE1, a down-counter loads WINDOW.
  - In STAGE1, each cycle without a cond1 hit decrements it.
  - When it reaches 0 without a hit: go to STAGE0 with cnt=0.
  - WINDOW=0 means no timeout.
  - A cond1 hit in the same cycle as expiry fires.
- Undefined: no WINDOW register; its address reads 0. STAGE1 waits indefinitely.

Test Plan:
- Basic match: MASK0=0xFF, MATCH0=0x5A, arm; drive 0x00,0x5A,0x5A -> one trigger_out pulse, in the cycle sample_out=0x5A (first); state reads 3; no second pulse.
- Occurrence count: COUNT=3, same condition; drive 0x5A,0x00,0x5A,0x00,0x5A -> pulse only after the third 0x5A; COUNT read before fire shows cnt=2.
- Edge: MASK0=EDGE0=MATCH0=0x1, arm with sample held at 1 -> no pulse; then 0 then 1 -> pulse one cycle after the 1.
- Sequence: seq_en=1, cond0 match 0x01, cond1 match 0x02 (MASK 0xFF); drive 0x02,0x01,0x03,0x02 -> state 1,2,2 then fire on 0x02; no fire on the first 0x02.
- Priority and reset: CTRL write 0 in the same cycle as a matching sample -> no pulse, state IDLE. Arm, reach STAGE1, assert rst -> state 0, trigger_out 0, all registers read 0.
- (ILA_TRIG_TIMEOUT_EN) WINDOW=4, sequence config, cond0 hit, then 4 non-matching cycles -> back to STAGE0; a cond1 hit afterwards does not fire.
